// File: rtl/div_4bit_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Controller state encoding and the default operand width live here.
package div_4bit_seq_pkg;

    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Quotient reported for a zero divisor: all ones at the given width.
    function automatic logic [31:0] dz_quotient(input int width);
        logic [31:0] ones_v;
        ones_v = 32'd0;
        for (int i = 0; i < width; i++) begin
            ones_v[i] = 1'b1;
        end
        return ones_v;
    endfunction

endpackage

// File: rtl/div_4bit_seq_if.sv
// Operand/result handshake bundle between the operand source and the divider.
// The master drives start/a/b; the slave (divider) returns busy/done/q/r/div_zero.
interface div_4bit_seq_if
    import div_4bit_seq_pkg::*;
#(
    parameter int N = N_DEF
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         div_zero;

    modport master (
        output start, a, b,
        input  busy, done, q, r, div_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, div_zero
    );
endinterface

// File: rtl/div_4bit_seq_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step
    import div_4bit_seq_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] rem,
    input  logic         in_bit,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] next_rem,
    output logic         q_bit
);
    logic [N:0] shifted_s;
    logic [N:0] trial_s;

    // The shifted remainder can exceed N bits when the divisor MSB is set,
    // so the trial subtraction keeps one extra bit to expose the borrow.
    always_comb begin
        shifted_s = {rem, in_bit};
        trial_s   = shifted_s - {1'b0, divisor};
        q_bit     = ~trial_s[N];
        if (q_bit) begin
            next_rem = trial_s[N-1:0];
        end else begin
            next_rem = shifted_s[N-1:0];
        end
    end
endmodule

// File: rtl/div_4bit_seq.sv
// Multi-cycle restoring divider: one shared step unit, one quotient bit per
// cycle MSB first, with a start/busy/done handshake and divide-by-zero flag.
module div_4bit_seq
    import div_4bit_seq_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic          clk,
    input  logic          rst,
    div_4bit_seq_if.slave bus
);
    localparam int            CW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] COUNT_LOAD = CW'(N - 1);
    localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
    localparam logic [N-1:0]  ZERO_N     = {N{1'b0}};
    localparam logic [N-1:0]  DZ_Q       = N'(dz_quotient(N));

    state_e        state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;

    logic          accept_s;
    logic [N-1:0]  step_rem_s;
    logic          step_bit_s;

    // A start seen while the done pulse is still out is deliberately dropped.
    assign accept_s = (state_q == ST_IDLE) && bus.start && !done_q;

    div_step #(.N(N)) u_step (
        .rem      (rem_q),
        .in_bit   (a_sh_q[N-1]),
        .divisor  (b_q),
        .next_rem (step_rem_s),
        .q_bit    (step_bit_s)
    );

    // State register and all datapath/output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= ZERO_N;
            b_q     <= ZERO_N;
            rem_q   <= ZERO_N;
            quo_q   <= ZERO_N;
            count_q <= COUNT_ZERO;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= ZERO_N;
            r_q     <= ZERO_N;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (bus.b == ZERO_N) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (count_q == COUNT_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath updates and registered-output staging.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        count_d = count_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        busy_d  = (state_d == ST_CALC);
        done_d  = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    a_sh_d  = bus.a;
                    b_d     = bus.b;
                    count_d = COUNT_LOAD;
                    // A zero divisor skips CALC, so its result is staged here.
                    if (bus.b == ZERO_N) begin
                        quo_d = DZ_Q;
                        rem_d = bus.a;
                    end else begin
                        quo_d = ZERO_N;
                        rem_d = ZERO_N;
                    end
                end else begin
                    a_sh_d = a_sh_q;
                end
            end
            ST_CALC: begin
                rem_d  = step_rem_s;
                quo_d  = {quo_q[N-2:0], step_bit_s};
                a_sh_d = {a_sh_q[N-2:0], 1'b0};
                if (count_q != COUNT_ZERO) begin
                    count_d = count_q - CW'(1);
                end else begin
                    count_d = count_q;
                end
            end
            ST_DONE: begin
                q_d  = quo_q;
                r_d  = rem_q;
                dz_d = (b_q == ZERO_N);
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.q        = q_q;
    assign bus.r        = r_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_div_4bit_seq.sv
// Self-checking bench for div_4bit_seq: cycle-level behavioural model plus
// hand-computed expectations for the directed operations.
module tb_div_4bit_seq;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_4bit_seq_if #(.N(N)) bus ();
    div_4bit_seq #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int q;
        int r;
        int dz;
        int lat;
    } want_t;

    want_t want_fifo[$];
    want_t cur_w;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: edges since acceptance, results from integer / and %.
    logic m_active    = 1'b0;
    logic m_busy      = 1'b0;
    logic m_done      = 1'b0;
    logic m_res_valid = 1'b1;
    int   m_e = 0, m_lat = 0, m_a = 0, m_b = 0, m_q = 0, m_r = 0, m_dz = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active    <= 1'b0;
            m_busy      <= 1'b0;
            m_done      <= 1'b0;
            m_res_valid <= 1'b1;
            m_e         <= 0;
            m_q         <= 0;
            m_r         <= 0;
            m_dz        <= 0;
        end else if (m_active) begin
            if (m_e == m_lat) begin
                m_active <= 1'b0;
                m_done   <= 1'b0;
            end else begin
                m_e    <= m_e + 1;
                m_busy <= (m_b != 0) && (m_e + 1 < N);
                if (m_e + 1 == m_lat) begin
                    m_done      <= 1'b1;
                    m_res_valid <= 1'b1;
                    m_q         <= (m_b == 0) ? (1 << N) - 1 : m_a / m_b;
                    m_r         <= (m_b == 0) ? m_a : m_a % m_b;
                    m_dz        <= (m_b == 0) ? 1 : 0;
                end
            end
        end else if (bus.start) begin
            m_active    <= 1'b1;
            m_e         <= 0;
            m_a         <= int'(bus.a);
            m_b         <= int'(bus.b);
            m_lat       <= (bus.b == 4'd0) ? 1 : N + 1;
            m_busy      <= (bus.b != 4'd0);
            m_res_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_q", int'(bus.q), 0);
            chk("rst_r", int'(bus.r), 0);
            chk("rst_dz", int'(bus.div_zero), 0);
        end else begin
            chk("busy", int'(bus.busy), int'(m_busy));
            chk("done", int'(bus.done), int'(m_done));
            if (m_res_valid) begin
                chk("q", int'(bus.q), m_q);
                chk("r", int'(bus.r), m_r);
                chk("div_zero", int'(bus.div_zero), m_dz);
            end
            if (m_done) begin
                chk("pending_expect", (want_fifo.size() > 0) ? 1 : 0, 1);
                if (want_fifo.size() > 0) begin
                    cur_w = want_fifo.pop_front();
                    chk("pin_q", m_q, cur_w.q);
                    chk("pin_r", m_r, cur_w.r);
                    chk("pin_dz", m_dz, cur_w.dz);
                    chk("pin_latency", m_e, cur_w.lat);
                end
            end
        end
    end

    task automatic run_op(input int a, input int b, input int eq, input int er,
                          input int edz, input int elat);
        want_fifo.push_back('{q: eq, r: er, dz: edz, lat: elat});
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'(a);
        bus.b     = 4'(b);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 4'(a + 7);
        bus.b     = 4'(b + 3);
        repeat (elat + 1) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        run_op(13, 3, 4, 1, 0, 5);
        run_op(15, 1, 15, 0, 0, 5);
        run_op(7, 9, 0, 7, 0, 5);
        run_op(14, 15, 0, 14, 0, 5);
        run_op(9, 0, 15, 9, 1, 1);
        run_op(8, 2, 4, 0, 0, 5);

        // start held high: only 13/3 and then the pair present once idle again
        want_fifo.push_back('{q: 4, r: 1, dz: 0, lat: 5});
        want_fifo.push_back('{q: 3, r: 1, dz: 0, lat: 5});
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd13;
        bus.b     = 4'd3;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.a = 4'(i + 6);
            bus.b = 4'(i);
        end
        @(negedge clk);
        bus.a = 4'd10;
        bus.b = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        repeat (7) @(negedge clk);

        // reset in the second CALC cycle of 11/2
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd11;
        bus.b     = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        run_op(11, 2, 5, 1, 0, 5);

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(a, b, a / b, a % b, 0, 5);
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
